// File: rtl/cplx_alu_pkg.sv
// Shared definitions for the sequential complex-number ALU.
// Holds the opcode encodings and the controller state type used by
// cplx_alu_seq. No ports; import with cplx_alu_pkg::*.
package cplx_alu_pkg;

    localparam logic [3:0] OP_A    = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_CMUL = 4'b0100;
    localparam logic [3:0] OP_PMUL = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_CONJ = 4'b1011;
    localparam logic [3:0] OP_NEG  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cplx_narrow.sv
// Narrows one wide signed component to W bits.
// Ports:
//   din      in  IW  wide two's-complement value
//   use_frac in  1   1 = arithmetic-shift right by FRAC first (products only)
//   dout     out W   narrowed value (saturated or wrapped per SAT)
//   ovf      out 1   value did not fit in the signed W-bit range
module cplx_narrow #(
    parameter int IW   = 65,
    parameter int W    = 32,
    parameter int FRAC = 0,
    parameter int SAT  = 1
) (
    input  logic [IW-1:0] din,
    input  logic          use_frac,
    output logic [W-1:0]  dout,
    output logic          ovf
);

    logic signed [IW-1:0] shifted;
    logic                 fits;

    always_comb begin
        shifted = use_frac ? ($signed(din) >>> FRAC) : $signed(din);
        // Fits when every bit above the W-bit sign bit repeats that sign bit.
        fits    = (shifted[IW-1:W-1] == {(IW-W+1){shifted[W-1]}});
        dout    = shifted[W-1:0];
        ovf     = 1'b0;
        if (!fits) begin
            ovf = 1'b1;
            if (SAT != 0) begin
                dout = shifted[IW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/cplx_alu_seq.sv
// Sequential complex ALU with one shared signed W x W multiplier.
// Operands are {Re, Im}, each a W-bit two's-complement fixed-point value.
// Ports:
//   clock, reset  posedge clock, synchronous active-low reset
//   start         request, sampled only while idle
//   opr, inA, inB opcode and operands, captured with start
//   outAB         registered result, held until the next completion
//   done          one-cycle pulse when outAB/ovf/err update
//   busy          high whenever the controller is not idle
//   ovf, err      narrowing overflow / illegal opcode, registered with outAB
//   dbg_state     current controller state (state_t encoding)
// Handshake: a request is accepted on any edge where start=1 and busy=0;
// start while busy is dropped. Exactly one done pulse follows each accepted
// request (unless reset intervenes), in the cycle where busy is already low,
// so a new start may be presented in that same done cycle.
module cplx_alu_seq
    import cplx_alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 0,
    parameter int SAT  = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     opr,
    input  logic [2*W-1:0] inA,
    input  logic [2*W-1:0] inB,
    output logic [2*W-1:0] outAB,
    output logic           done,
    output logic           busy,
    output logic           ovf,
    output logic           err,
    output logic [1:0]     dbg_state
);

    localparam int AW = 2 * W + 1;

    state_t                state_q, state_d;
    logic   [3:0]          op_q;
    logic   [2*W-1:0]      a_q, b_q;
    logic   [1:0]          cnt_q;
    logic   [AW-1:0]       acc_re_q, acc_im_q;

    logic                  is_mul;
    logic   [1:0]          last_cnt;
    logic signed [W-1:0]   mul_x, mul_y;
    logic signed [2*W-1:0] prod;
    logic   [AW-1:0]       prod_ext;
    logic   [AW-1:0]       res_re, res_im;
    logic                  use_frac, illegal;
    logic   [W-1:0]        re_n, im_n;
    logic                  ovf_re, ovf_im;

    function automatic logic [AW-1:0] sx(input logic [W-1:0] v);
        return {{(W+1){v[W-1]}}, v};
    endfunction

    assign is_mul   = (op_q == OP_CMUL) || (op_q == OP_PMUL);
    assign last_cnt = (op_q == OP_CMUL) ? 2'd3 : 2'd1;

    // Product order per counter: 0 ArBr, 1 AiBi, 2 ArBi, 3 AiBr.
    // PMUL only walks steps 0 and 1.
    assign mul_x    = cnt_q[0] ? a_q[W-1:0] : a_q[2*W-1:W];
    assign mul_y    = (cnt_q[0] ^ cnt_q[1]) ? b_q[W-1:0] : b_q[2*W-1:W];
    assign prod     = mul_x * mul_y;
    assign prod_ext = {prod[2*W-1], prod};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EXEC;
            ST_EXEC: state_d = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (cnt_q == last_cnt) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Unshifted results for all non-multiply opcodes; sign-extension to AW
    // gives the W+1-bit headroom needed before narrowing.
    always_comb begin
        res_re   = '0;
        res_im   = '0;
        use_frac = 1'b0;
        illegal  = 1'b0;
        case (op_q)
            OP_A:    begin res_re = sx(a_q[2*W-1:W]); res_im = sx(a_q[W-1:0]); end
            OP_B:    begin res_re = sx(b_q[2*W-1:W]); res_im = sx(b_q[W-1:0]); end
            OP_ADD:  begin
                res_re = sx(a_q[2*W-1:W]) + sx(b_q[2*W-1:W]);
                res_im = sx(a_q[W-1:0]) + sx(b_q[W-1:0]);
            end
            OP_SUB:  begin
                res_re = sx(a_q[2*W-1:W]) - sx(b_q[2*W-1:W]);
                res_im = sx(a_q[W-1:0]) - sx(b_q[W-1:0]);
            end
            OP_CMUL, OP_PMUL: begin
                res_re   = acc_re_q;
                res_im   = acc_im_q;
                use_frac = 1'b1;
            end
            OP_EQ:   res_im = {{(AW-1){1'b0}}, (a_q == b_q)};
            OP_CONJ: begin res_re = sx(a_q[2*W-1:W]); res_im = '0 - sx(a_q[W-1:0]); end
            OP_NEG:  begin res_re = '0 - sx(a_q[2*W-1:W]); res_im = '0 - sx(a_q[W-1:0]); end
            default: illegal = 1'b1;
        endcase
    end

    cplx_narrow #(.IW(AW), .W(W), .FRAC(FRAC), .SAT(SAT)) u_narrow_re (
        .din      (res_re),
        .use_frac (use_frac),
        .dout     (re_n),
        .ovf      (ovf_re)
    );

    cplx_narrow #(.IW(AW), .W(W), .FRAC(FRAC), .SAT(SAT)) u_narrow_im (
        .din      (res_im),
        .use_frac (use_frac),
        .dout     (im_n),
        .ovf      (ovf_im)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            outAB    <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    op_q <= opr;
                    a_q  <= inA;
                    b_q  <= inB;
                end
                ST_EXEC: begin
                    cnt_q    <= '0;
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                end
                ST_MUL: begin
                    cnt_q <= cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: acc_re_q <= prod_ext;
                        2'd1: begin
                            if (op_q == OP_CMUL) acc_re_q <= acc_re_q - prod_ext;
                            else                 acc_im_q <= prod_ext;
                        end
                        2'd2: acc_im_q <= prod_ext;
                        default: acc_im_q <= acc_im_q + prod_ext;
                    endcase
                end
                ST_DONE: begin
                    outAB <= {re_n, im_n};
                    ovf   <= ovf_re | ovf_im;
                    err   <= illegal;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cplx_alu_seq.sv
// Bench for cplx_alu_seq: three instances (FRAC/SAT = 0/1, 0/0, 16/1) share
// one stimulus stream; a transaction-level model predicts every output each cycle.
module tb_cplx_alu_seq;

    typedef struct packed {
        logic        err;
        logic        ovf;
        logic [63:0] val;
    } res_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        start = 1'b0;
    logic [3:0]  opr   = 4'h0;
    logic [63:0] inA   = '0;
    logic [63:0] inB   = '0;

    logic [2:0][63:0] out_v;
    logic [2:0]       done_v, busy_v, ovf_v, err_v;
    logic [2:0][1:0]  st_v;

    cplx_alu_seq #(.W(32), .FRAC(0), .SAT(1)) dut0 (
        .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
        .outAB(out_v[0]), .done(done_v[0]), .busy(busy_v[0]), .ovf(ovf_v[0]),
        .err(err_v[0]), .dbg_state(st_v[0]));
    cplx_alu_seq #(.W(32), .FRAC(0), .SAT(0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
        .outAB(out_v[1]), .done(done_v[1]), .busy(busy_v[1]), .ovf(ovf_v[1]),
        .err(err_v[1]), .dbg_state(st_v[1]));
    cplx_alu_seq #(.W(32), .FRAC(16), .SAT(1)) dut2 (
        .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
        .outAB(out_v[2]), .done(done_v[2]), .busy(busy_v[2]), .ovf(ovf_v[2]),
        .err(err_v[2]), .dbg_state(st_v[2]));

    int frac_c [3] = '{0, 0, 16};
    bit sat_c  [3] = '{1'b1, 1'b0, 1'b1};

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    function automatic logic [32:0] nar(input logic signed [127:0] v, input bit prod,
                                        input int frac, input bit sat);
        logic signed [127:0] s;
        s = prod ? (v >>> frac) : v;
        if (s > 128'sd2147483647)  return sat ? {1'b1, 32'h7FFFFFFF} : {1'b1, s[31:0]};
        if (s < -128'sd2147483648) return sat ? {1'b1, 32'h80000000} : {1'b1, s[31:0]};
        return {1'b0, s[31:0]};
    endfunction

    function automatic res_t model(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int frac, input bit sat);
        logic signed [127:0] ar, ai, br, bi, re, im;
        logic [32:0] nr, ni;
        bit prod, bad;
        res_t r;
        ar = 128'($signed(a[63:32]));
        ai = 128'($signed(a[31:0]));
        br = 128'($signed(b[63:32]));
        bi = 128'($signed(b[31:0]));
        re = 0; im = 0; prod = 0; bad = 0;
        case (op)
            4'h0: begin re = ar; im = ai; end
            4'h1: begin re = br; im = bi; end
            4'h2: begin re = ar + br; im = ai + bi; end
            4'h3: begin re = ar - br; im = ai - bi; end
            4'h4: begin re = ar * br - ai * bi; im = ar * bi + ai * br; prod = 1; end
            4'h6: begin re = ar * br; im = ai * bi; prod = 1; end
            4'h8: im = (a == b) ? 128'sd1 : 128'sd0;
            4'hB: begin re = ar; im = -ai; end
            4'hC: begin re = -ar; im = -ai; end
            default: bad = 1;
        endcase
        nr = nar(re, prod, frac, sat);
        ni = nar(im, prod, frac, sat);
        r.err = bad;
        r.ovf = nr[32] | ni[32];
        r.val = {nr[31:0], ni[31:0]};
        return r;
    endfunction

    function automatic int lat(input logic [3:0] op);
        return (op == 4'h4) ? 6 : (op == 4'h6) ? 4 : 2;
    endfunction

    // Model bookkeeping: one outstanding request, result due at accept edge + latency.
    int          cyc = 0;
    int          m_due = 0;
    bit          m_active = 0;
    res_t        pend [3];
    logic [63:0] e_out [3];
    logic        e_ovf [3];
    logic        e_err [3];
    logic        e_done = 0;
    logic        e_busy = 0;

    always @(posedge clock) begin
        cyc++;
        e_done = 0;
        if (!reset) begin
            m_active = 0;
            for (int d = 0; d < 3; d++) begin
                e_out[d] = '0; e_ovf[d] = 0; e_err[d] = 0;
            end
        end else begin
            if (start && !m_active) begin
                m_active = 1;
                m_due    = cyc + lat(opr);
                for (int d = 0; d < 3; d++) pend[d] = model(opr, inA, inB, frac_c[d], sat_c[d]);
            end
            if (m_active && cyc == m_due) begin
                m_active = 0;
                e_done   = 1;
                for (int d = 0; d < 3; d++) begin
                    e_out[d] = pend[d].val; e_ovf[d] = pend[d].ovf; e_err[d] = pend[d].err;
                end
            end
        end
        e_busy = m_active;
    end

    // ---------------- scoreboard / driver tasks ----------------
    task automatic check_cycle();
        logic [67:0] got, exp;
        if (cyc > 0) begin
            for (int d = 0; d < 3; d++) begin
                got = {err_v[d], ovf_v[d], done_v[d], busy_v[d], out_v[d]};
                exp = {e_err[d], e_ovf[d], e_done, e_busy, e_out[d]};
                n_vec++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL cycle%0d dut%0d err/ovf/done/busy/out got %b%b%b%b %h expected %b%b%b%b %h",
                             cyc, d, got[67], got[66], got[65], got[64], got[63:0],
                             exp[67], exp[66], exp[65], exp[64], exp[63:0]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        start = 1'b1; opr = op; inA = a; inB = b;
        tick();
        start = 1'b0; opr = 4'($urandom); inA = {$urandom, $urandom}; inB = {$urandom, $urandom};
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (done_v[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_vec++;
        if (done_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s no done within 20 cycles", name);
        end
    endtask

    function automatic logic [31:0] rc();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'h0;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'hB, 4'hC};
        if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 8)];
        return 4'($urandom_range(0, 15));
    endfunction

    localparam logic [63:0] A34  = {32'd3, 32'd4};
    localparam logic [63:0] B1M2 = {32'd1, 32'hFFFFFFFE};

    // ---------------- stimulus ----------------
    initial begin
        int n;

        // Pin the model to hand-computed values.
        chk("pin_add",   model(4'h2, A34, B1M2, 0, 1), {1'b0, 1'b0, 64'h00000004_00000002});
        chk("pin_cmul",  model(4'h4, A34, B1M2, 0, 1), {1'b0, 1'b0, 64'h0000000B_FFFFFFFE});
        chk("pin_pmul",  model(4'h6, A34, B1M2, 0, 1), {1'b0, 1'b0, 64'h00000003_FFFFFFF8});
        chk("pin_sat",   model(4'h2, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 0, 1),
            {1'b0, 1'b1, 64'h7FFFFFFF_00000000});
        chk("pin_wrap",  model(4'h2, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 0, 0),
            {1'b0, 1'b1, 64'h80000000_00000000});
        chk("pin_q16",   model(4'h4, 64'h00018000_00000000, 64'h00020000_00000000, 16, 1),
            {1'b0, 1'b0, 64'h00030000_00000000});
        chk("pin_negmin", model(4'hC, 64'h80000000_00000000, 64'h0, 0, 1),
            {1'b0, 1'b1, 64'h7FFFFFFF_00000000});
        chk("pin_illegal", model(4'hF, A34, B1M2, 0, 1), {1'b1, 1'b0, 64'h0});
        chk("pin_eq",    model(4'h8, A34, A34, 0, 1), {1'b0, 1'b0, 64'h1});

        repeat (3) tick();
        chk("reset_out",  out_v[0], 64'h0);
        chk("reset_busy", busy_v[0], 1'b0);
        reset = 1'b1;
        tick();

        issue(4'h2, A34, B1M2);
        wait_done("add", n);
        chk("add_latency", n, 2);
        chk("add_out", {ovf_v[0], out_v[0]}, {1'b0, 64'h00000004_00000002});

        issue(4'h4, A34, B1M2);
        wait_done("cmul", n);
        chk("cmul_latency", n, 6);
        chk("cmul_out", out_v[0], 64'h0000000B_FFFFFFFE);

        issue(4'h6, A34, B1M2);
        wait_done("pmul", n);
        chk("pmul_latency", n, 4);
        chk("pmul_out", out_v[0], 64'h00000003_FFFFFFF8);

        issue(4'h2, 64'h7FFFFFFF_00000000, 64'h00000001_00000000);
        wait_done("sat", n);
        chk("sat_out",  {ovf_v[0], out_v[0][63:32]}, {1'b1, 32'h7FFFFFFF});
        chk("wrap_out", {ovf_v[1], out_v[1][63:32]}, {1'b1, 32'h80000000});

        issue(4'h4, 64'h00018000_00000000, 64'h00020000_00000000);
        wait_done("q16", n);
        chk("q16_out", out_v[2], 64'h00030000_00000000);

        // start during a busy CMUL is dropped
        issue(4'h4, A34, B1M2);
        tick(); tick();
        start = 1'b1; opr = 4'h3;
        tick();
        start = 1'b0;
        wait_done("ignore", n);
        chk("ignore_latency", n, 3);
        chk("ignore_out", out_v[0], 64'h0000000B_FFFFFFFE);
        repeat (8) tick();

        // reset in the third MUL cycle
        issue(4'h4, A34, B1M2);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("midrst_out", {done_v[0], busy_v[0], out_v[0]}, {1'b0, 1'b0, 64'h0});
        reset = 1'b1;
        repeat (8) tick();
        issue(4'h2, A34, B1M2);
        wait_done("post_reset_add", n);
        chk("post_reset_add", out_v[0], 64'h00000004_00000002);

        issue(4'hF, A34, B1M2);
        wait_done("illegal", n);
        chk("illegal_out", {err_v[0], out_v[0]}, {1'b1, 64'h0});

        // randomized traffic, including starts while busy and rare resets
        for (int i = 0; i < 500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            opr   = pick_op();
            inA   = {rc(), rc()};
            inB   = ($urandom_range(0, 3) == 0) ? inA : {rc(), rc()};
            reset = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
